prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader: the write side of the program-memory interface that the pipelined MCU fetches from. It receives a framed byte stream over a valid/ready handshake, assembles 17-bit instruction words, and writes them sequentially into program memory starting at address 0. It holds the MCU in reset (`cpu_hold`) until a complete, valid image has been written.

## Interface
- `INST_W`, 17: instruction word width; must match the program memory data width.
- `ADDR_W`, 8: program memory address width. Maximum image size is 2^ADDR_W words.
- `HEADER`, 8'hA5: frame start byte.
- `clk`  in  1: the single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `byte_in`  in  8: stream data byte.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_ready`  out  1: the loader accepts a byte this cycle.
- `pm_we`  out  1: program memory write strobe, one cycle per word.
- `pm_addr`  out  ADDR_W: write address.
- `pm_wdata`  out  INST_W: write data.
- `cpu_hold`  out  1: when high, holds the MCU in reset.
- `load_done`  out  1: the last frame completed successfully (level).
- `load_err`  out  1: the last frame was aborted or failed (level).

## Operation
- A byte transfers on a rising edge when `byte_valid && byte_ready`.
- Frame format: `HEADER`, then COUNT, then COUNT words of 3 bytes each, then CSUM.
  - COUNT is the word count; 0 means 256.
  - Each word is little-endian: b0 = data[7:0], b1 = data[15:8], b2[0] = data[16], b2[7:1] must be 0.
  - CSUM is the mod-256 sum of COUNT and all word bytes. The header is excluded.
- States and transitions:
  - IDLE: non-header bytes are discarded. When `HEADER` is accepted, go to COUNT, set `cpu_hold`=1, and clear `load_done` and `load_err`.
  - COUNT: latch the count into a 9-bit remaining counter, reset the address to 0, seed the checksum with the count byte, then go to B0.
  - B0 → B1 → B2: accept one byte each and accumulate the checksum.
    - In B2, if b2[7:1]≠0: set `load_err`, go to IDLE, and issue no write.
    - Otherwise go to WRITE.
  - WRITE: one cycle with `byte_ready`=0. Assert `pm_we` with the current `pm_addr`/`pm_wdata`, then increment the address and decrement the remaining counter.
    - If words remain, go to B0.
    - If none remain, go to CSUM.
  - CSUM: accept one byte.
    - If it matches the running checksum: `load_done`=1, `cpu_hold`=0.
    - If it does not match: `load_err`=1, `cpu_hold` stays 1.
    - Either way, go to IDLE.
- Words are written as soon as they are received. A failed frame leaves any partial image in memory; `cpu_hold` keeps the MCU from running it.
- A header byte received mid-frame is treated as data. There is no resynchronisation except through reset.

## Timing
- Reset values:
  - state IDLE, `byte_ready`=1.
  - `pm_we`=0, `pm_addr`=0, `pm_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `load_err`=0.
  - checksum and counter 0.
- All outputs are registered or decoded from state; there are no combinational paths from input to output.
- `byte_ready` is 1 in every state except WRITE.
- `pm_we` rises on the edge that accepts b2 and falls one cycle later. `pm_addr`/`pm_wdata` are stable while `pm_we` is high.
- Minimum per word: 4 cycles (3 bytes + WRITE). A full frame at a continuous stream takes 2 + 4·N + 1 cycles.
- Address wrap: with COUNT=0, writes go to 0..255. The 8-bit address wraps to 0 after the final write and is never reused within the frame.
- `byte_valid` low simply stalls in the current state; there is no timeout.
- If `reset` is asserted mid-frame, all outputs take their reset values immediately (asynchronously). The next frame starts at address 0.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: the CSUM byte is expected and checked, as described above.
- `PROG_LOADER_CHECKSUM_EN` undefined:
  - No CSUM byte and no checksum logic.
  - After the final WRITE, set `load_done`=1 and `cpu_hold`=0, then go to IDLE.
  - `load_err` is only set by a bad b2.

## Structure
- Shared package `mcu_pkg` holds:
  - the `INST_W` and `ADDR_W` defaults;
  - the `HEADER` constant;
  - the loader state enum (IDLE, COUNT, B0, B1, B2, WRITE, CSUM).
- One sub-module, `prog_csum`: an 8-bit accumulator with clear/seed/add and a compare output. It is instantiated only under `PROG_LOADER_CHECKSUM_EN`.

## Test plan
- Single word, no gaps:
  - Stimulus: A5, 01, 34, 12, 01, 48.
  - Required: one `pm_we` pulse at addr 0 with data 17'h11234, then `load_done`=1, `cpu_hold`=0.
- Same frame with CSUM=49:
  - Required: the write still occurs, then `load_err`=1 and `cpu_hold`=1.
- Bad upper bits:
  - Stimulus: A5, 01, 00, 00, 02.
  - Required: no `pm_we`, `load_err`=1, back to IDLE; a following valid frame then completes with `load_err` cleared.
- Leading garbage and a full image:
  - Stimulus: garbage 00, FF before A5, then COUNT=00 with 256 words (random `byte_valid` gaps).
  - Required: garbage is ignored; exactly 256 writes at addr 0..255 in order; correct CSUM gives `load_done`.
- Reset mid-frame:
  - Stimulus: drive `reset` low after 2 words of a 4-word frame.
  - Required: outputs return to reset values within the same cycle; a new 1-word frame writes addr 0.
- Build without the macro:
  - Stimulus: A5, 01, 34, 12, 01.
  - Required: `load_done`=1 on the cycle after WRITE; no CSUM byte is consumed.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared MCU package: program-memory geometry defaults, the loader frame
// header byte and the program-loader state encoding.
package mcu_pkg;

  localparam int unsigned INST_W_DEF = 17;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam logic [7:0]  HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CSUM
  } ld_state_e;

endpackage

// File: rtl/prog_csum.sv
// 8-bit mod-256 checksum accumulator for the program loader.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        clear the sum to 0
//   i_seed       load the sum with i_data
//   i_add        add i_data to the sum
//   i_data       byte to seed/add, and the byte compared against the sum
//   o_match      current sum equals i_data
module prog_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_seed,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sum <= '0;
    else if (i_clr)  r_sum <= '0;
    else if (i_seed) r_sum <= i_data;
    else if (i_add)  r_sum <= r_sum + i_data;
  end

  assign o_match = (r_sum == i_data);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives HEADER, COUNT, COUNT x 3-byte
// little-endian words (and CSUM when PROG_LOADER_CHECKSUM_EN is defined)
// over a valid/ready byte stream, writes words to program memory from
// address 0 and holds the MCU in reset until a good image is loaded.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   byte_in/valid/ready    byte stream handshake
//   pm_we/addr/wdata       program memory write port (one strobe per word)
//   cpu_hold               holds the MCU in reset while high
//   load_done / load_err   level status of the last frame
// Build option: PROG_LOADER_CHECKSUM_EN enables the trailing CSUM byte.
module prog_loader
  import mcu_pkg::*;
#(
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [7:0]  HEADER = HEADER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [INST_W-1:0] pm_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  ld_state_e         r_state, w_next;
  logic [7:0]        r_b0, r_b1;
  logic [ADDR_W:0]   r_remain;
  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_wdata;
  logic              r_we, r_hold, r_done, r_err;
  logic              w_xfer, w_hdr, w_b2_bad, w_last;

  assign byte_ready = (r_state != S_WRITE);
  assign w_xfer     = byte_valid && byte_ready;
  assign w_hdr      = (byte_in == HEADER);
  assign w_b2_bad   = |byte_in[7:1];
  assign w_last     = (r_remain == (ADDR_W+1)'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic w_cs_clr, w_cs_seed, w_cs_add, w_cs_match;

  assign w_cs_clr  = w_xfer && (r_state == S_IDLE) && w_hdr;
  assign w_cs_seed = w_xfer && (r_state == S_COUNT);
  assign w_cs_add  = w_xfer && ((r_state == S_B0) || (r_state == S_B1) ||
                                (r_state == S_B2));

  prog_csum u_csum (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_cs_clr),
    .i_seed  (w_cs_seed),
    .i_add   (w_cs_add),
    .i_data  (byte_in),
    .o_match (w_cs_match)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_xfer && w_hdr) w_next = S_COUNT;
      S_COUNT: if (w_xfer) w_next = S_B0;
      S_B0:    if (w_xfer) w_next = S_B1;
      S_B1:    if (w_xfer) w_next = S_B2;
      S_B2:    if (w_xfer) w_next = w_b2_bad ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (!w_last) w_next = S_B0;
`ifdef PROG_LOADER_CHECKSUM_EN
        else         w_next = S_CSUM;
`else
        else         w_next = S_IDLE;
`endif
      end
      S_CSUM:  if (w_xfer) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_remain <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // Strobe is high only for the WRITE cycle that follows a good b2.
      r_we <= w_xfer && (r_state == S_B2) && !w_b2_bad;
      unique case (r_state)
        S_IDLE: if (w_xfer && w_hdr) begin
          r_hold <= 1'b1;
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
        S_COUNT: if (w_xfer) begin
          r_remain <= (byte_in == 8'h00) ? (ADDR_W+1)'(256)
                                         : (ADDR_W+1)'(byte_in);
          r_addr   <= '0;
        end
        S_B0: if (w_xfer) r_b0 <= byte_in;
        S_B1: if (w_xfer) r_b1 <= byte_in;
        S_B2: if (w_xfer) begin
          if (w_b2_bad) r_err   <= 1'b1;
          else          r_wdata <= INST_W'({byte_in[0], r_b1, r_b0});
        end
        S_WRITE: begin
          // Address advances after the strobe cycle; after word 256 it
          // wraps to 0 but the frame has no more writes to issue.
          r_addr   <= r_addr + 1'b1;
          r_remain <= r_remain - 1'b1;
`ifndef PROG_LOADER_CHECKSUM_EN
          if (w_last) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: if (w_xfer) begin
          if (w_cs_match) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end else begin
            r_err  <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign pm_we     = r_we;
  assign pm_addr   = r_addr;
  assign pm_wdata  = r_wdata;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, pm_we, cpu_hold, load_done, load_err;
  logic [7:0]  pm_addr;
  logic [16:0] pm_wdata;

  int unsigned nvec = 0;
  int unsigned errors = 0;
  bit          gap_en = 1'b0;

  logic [7:0]  wa_q[$];
  logic [16:0] wd_q[$];

  // {byte_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err}
  localparam logic [29:0] RST_VEC = {1'b1, 1'b0, 8'h00, 17'h0, 1'b1, 1'b0, 1'b0};

  prog_loader #(.INST_W(17), .ADDR_W(8), .HEADER(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_we) begin
      wa_q.push_back(pm_addr);
      wd_q.push_back(pm_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", nvec);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    int unsigned g;
    if (gap_en) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        @(negedge clk);
        byte_valid = 1'b0;
      end
    end
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready=%b required 1", byte_ready);
    end else begin
      @(posedge clk);
    end
    #1 byte_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({byte_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h required %h",
               {byte_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err}, RST_VEC);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    clear_q();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34);
    send_byte(8'h12); send_byte(8'h01);
    @(negedge clk);
    nvec++;
    if ({pm_we, byte_ready, pm_addr, pm_wdata} !== {1'b1, 1'b0, 8'h00, 17'h11234}) begin
      errors++;
      $display("FAIL write_cycle: we/ready/addr/data=%b/%b/%h/%h required 1/0/00/11234",
               pm_we, byte_ready, pm_addr, pm_wdata);
    end
    @(negedge clk);
`ifdef PROG_LOADER_CHECKSUM_EN
    nvec++;
    if ({pm_we, byte_ready, load_done, cpu_hold} !== 4'b0101) begin
      errors++;
      $display("FAIL csum_wait: we/ready/done/hold=%b required 0101",
               {pm_we, byte_ready, load_done, cpu_hold});
    end
    send_byte(8'h48);
    @(negedge clk);
`else
    nvec++;
    if ({pm_we, load_done, cpu_hold, load_err} !== 4'b0100) begin
      errors++;
      $display("FAIL done_after_write: we/done/hold/err=%b required 0100",
               {pm_we, load_done, cpu_hold, load_err});
    end
`endif
    settle();
    nvec++;
    if ({load_done, cpu_hold, load_err, byte_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL single_status: done/hold/err/ready=%b required 1001",
               {load_done, cpu_hold, load_err, byte_ready});
    end
    nvec++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 17'h11234) begin
      errors++;
      $display("FAIL single_write: nwrites=%0d addr=%h data=%h required 1/00/11234",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 8'hxx,
               (wd_q.size() > 0) ? wd_q[0] : 17'hx);
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    clear_q();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34);
    send_byte(8'h12); send_byte(8'h01); send_byte(8'h49);
    settle();
    nvec++;
    if ({load_done, cpu_hold, load_err} !== 3'b011) begin
      errors++;
      $display("FAIL bad_csum_status: done/hold/err=%b required 011",
               {load_done, cpu_hold, load_err});
    end
    nvec++;
    if (wa_q.size() != 1 || wd_q[0] !== 17'h11234) begin
      errors++;
      $display("FAIL bad_csum_write: nwrites=%0d required 1", wa_q.size());
    end
  endtask
`endif

  task automatic test_bad_b2();
    clear_q();
    send_byte(8'hA5);
    @(negedge clk);
    nvec++;
    if ({load_done, load_err, cpu_hold} !== 3'b001) begin
      errors++;
      $display("FAIL header_clears: done/err/hold=%b required 001",
               {load_done, load_err, cpu_hold});
    end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    settle();
    nvec++;
    if ({load_err, cpu_hold, load_done, byte_ready, wa_q.size() == 0} !== 5'b11011) begin
      errors++;
      $display("FAIL bad_b2: err/hold/done/ready=%b nwrites=%0d required 1101 and 0",
               {load_err, cpu_hold, load_done, byte_ready}, wa_q.size());
    end
    clear_q();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34);
    send_byte(8'h12); send_byte(8'h01);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h48);
`endif
    settle();
    nvec++;
    if ({load_done, load_err, cpu_hold} !== 3'b100 || wa_q.size() != 1 || wa_q[0] !== 8'h00) begin
      errors++;
      $display("FAIL recover_after_b2: done/err/hold=%b nwrites=%0d required 100 and 1",
               {load_done, load_err, cpu_hold}, wa_q.size());
    end
  endtask

  task automatic test_full_image();
    logic [7:0]  sum;
    logic [7:0]  iv;
    logic [16:0] exp_d;
    int unsigned bad;
    clear_q();
    gap_en = 1'b1;
    send_byte(8'h00); send_byte(8'hFF);
    @(negedge clk);
    nvec++;
    if ({load_done, cpu_hold, byte_ready, wa_q.size() == 0} !== 4'b1011) begin
      errors++;
      $display("FAIL garbage_ignored: done/hold/ready=%b nwrites=%0d required 101 and 0",
               {load_done, cpu_hold, byte_ready}, wa_q.size());
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      send_byte(iv);
      send_byte(~iv);
      send_byte({7'b0, iv[0]});
      sum = sum + iv + ~iv + {7'b0, iv[0]};
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(sum);
`endif
    gap_en = 1'b0;
    settle();
    nvec++;
    if (wa_q.size() != 256) begin
      errors++;
      $display("FAIL full_count: nwrites=%0d required 256", wa_q.size());
    end
    bad = 0;
    for (int i = 0; i < 256 && i < int'(wa_q.size()); i++) begin
      iv = 8'(i);
      exp_d = {iv[0], ~iv, iv};
      nvec++;
      if (wa_q[i] !== iv || wd_q[i] !== exp_d) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL full_word[%0d]: addr=%h data=%h required %h/%h",
                   i, wa_q[i], wd_q[i], iv, exp_d);
      end
    end
    nvec++;
    if ({load_done, cpu_hold, load_err, pm_addr} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL full_status: done/hold/err=%b addr=%h required 100/00",
               {load_done, cpu_hold, load_err}, pm_addr);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_byte(8'hA5); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h01);
    #2;
    nvec++;
    if ({pm_we, pm_addr, pm_wdata, cpu_hold} !== {1'b1, 8'h01, 17'h14433, 1'b1}) begin
      errors++;
      $display("FAIL mid_frame_write: we/addr/data/hold=%b/%h/%h/%b required 1/01/14433/1",
               pm_we, pm_addr, pm_wdata, cpu_hold);
    end
    reset = 1'b0;
    #1;
    nvec++;
    if ({byte_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err} !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h required %h",
               {byte_ready, pm_we, pm_addr, pm_wdata, cpu_hold, load_done, load_err}, RST_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h78);
    send_byte(8'h56); send_byte(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hCF);
`endif
    settle();
    nvec++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 17'h05678 ||
        {load_done, cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL after_reset_frame: nwrites=%0d done/hold=%b required 1 write 00/05678 and 10",
               wa_q.size(), {load_done, cpu_hold});
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_bad_b2();
    test_full_image();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
    $finish;
  end

endmodule
